// File: rtl/comp_bin_sar_if.sv
// comp_bin_sar_if: request/result bundle between the SAR search engine and its
// environment (requester plus external comparator).
//
// Handshake: i_Start is a request level sampled only while the engine is idle
// and not emitting its completion pulse; once accepted, o_Ocupado stays high
// until the search ends. o_Listo is a one-cycle completion strobe, and
// o_Resultado/o_Error are valid in that cycle and hold until the next accepted
// request. Comparator flags i_Mayor/i_Igual/i_Menor answer the o_B trial value
// after a fixed latency and are only looked at on the engine's sample cycle.
interface comp_bin_sar_if #(
  parameter int N = 8
);
  logic         i_Start;
  logic [N-1:0] o_B;
  logic         i_Mayor;
  logic         i_Igual;
  logic         i_Menor;
  logic         o_Ocupado;
  logic         o_Listo;
  logic [N-1:0] o_Resultado;
  logic         o_Error;

  // Environment side: issues requests, answers trials.
  modport master (
    output i_Start, i_Mayor, i_Igual, i_Menor,
    input  o_B, o_Ocupado, o_Listo, o_Resultado, o_Error
  );

  // Engine side.
  modport slave (
    input  i_Start, i_Mayor, i_Igual, i_Menor,
    output o_B, o_Ocupado, o_Listo, o_Resultado, o_Error
  );
endinterface

// File: rtl/comp_bin_sar.sv
// comp_bin_sar: successive-approximation search for a hidden value A using an
// external magnitude comparator with LAT cycles of latency. One bit is decided
// per trial, MSB first; the search stops early on equality.
//
// Optional build macro COMP_BIN_SAR_SIGNED_EN: o_B and o_Resultado are
// presented as two's complement (internal offset-binary value with the MSB
// inverted) for use with a signed comparator. Search order and timing are
// identical in both builds.
module comp_bin_sar #(
  parameter int N   = 8,
  parameter int LAT = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  comp_bin_sar_if.slave    bus,
  output logic [1:0]       o_Dbg_State
);

  localparam int KW = $clog2(N);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LAT);
  localparam logic [KW-1:0] K_TOP   = KW'(N - 1);
  localparam logic [N-1:0]  MSB     = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRY  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  work_q;    // bits decided so far (offset-binary domain)
  logic [N-1:0]  b_q;       // registered trial value presented on o_B
  logic [N-1:0]  res_q;
  logic [KW-1:0] k_q;       // bit currently under trial
  logic [CW-1:0] cnt_q;     // cycles the current trial has been stable
  logic          busy_q;
  logic          listo_q;
  logic          err_q;

  logic [N-1:0]  bit_d;
  logic [N-1:0]  next_bit_d;
  logic [N-1:0]  work_d;
  logic          keep_d;
  logic          flags_ok_d;
  logic          last_d;

  // Map the internal search value onto the comparator's operand encoding.
  function automatic logic [N-1:0] out_map(input logic [N-1:0] v);
`ifdef COMP_BIN_SAR_SIGNED_EN
    return v ^ MSB;
`else
    return v;
`endif
  endfunction

  // Decision for the bit under trial. The bit is kept when the hidden value is
  // at or above the trial; with inconsistent flags the same rule yields the
  // partial value reported alongside o_Error.
  always_comb begin
    bit_d      = {{(N-1){1'b0}}, 1'b1} << k_q;
    next_bit_d = bit_d >> 1;
    keep_d     = bus.i_Mayor | bus.i_Igual;
    work_d     = keep_d ? (work_q | bit_d) : work_q;
    flags_ok_d = $onehot({bus.i_Mayor, bus.i_Igual, bus.i_Menor});
    last_d     = bus.i_Igual || (k_q == '0);
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      listo_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A request coinciding with the completion pulse is dropped.
          if (bus.i_Start && !listo_q) begin
            work_q  <= '0;
            k_q     <= K_TOP;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            b_q     <= out_map(MSB);
            busy_q  <= 1'b1;
            state_q <= TRY;
          end
        end
        TRY: begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (!flags_ok_d) begin
            err_q   <= 1'b1;
            work_q  <= work_d;
            b_q     <= '0;
            state_q <= DONE;
          end else if (last_d) begin
            work_q  <= work_d;
            b_q     <= '0;
            state_q <= DONE;
          end else begin
            work_q <= work_d;
            k_q    <= k_q - 1'b1;
            cnt_q  <= '0;
            b_q    <= out_map(work_d | next_bit_d);
          end
        end
        DONE: begin
          res_q   <= out_map(work_q);
          listo_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_B         = b_q;
  assign bus.o_Ocupado   = busy_q;
  assign bus.o_Listo     = listo_q;
  assign bus.o_Resultado = res_q;
  assign bus.o_Error     = err_q;
  assign o_Dbg_State     = state_q;

endmodule

// File: tb/tb_comp_bin_sar.sv
// tb_comp_bin_sar: directed bench for comp_bin_sar (N=8, LAT=2) with an ideal
// comparator model of two registered stages. Cycle c means "observed at the
// falling edge after the c-th rising edge following the one that took i_Start".
module tb_comp_bin_sar;
  localparam int N   = 8;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  comp_bin_sar_if #(.N(N)) bus();

  comp_bin_sar #(.N(N), .LAT(LAT)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .bus         (bus),
    .o_Dbg_State (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] hidden_a    = 8'h00;
  logic       force_en    = 1'b0;
  logic [2:0] force_flags = 3'b000;
  logic [2:0] stage1      = 3'b000;
  logic [2:0] flags_q     = 3'b000;
  logic [7:0] trial_q[$];
  logic [7:0] exp_q[$];

  // Ideal comparator, returns {A>B, A==B, A<B}.
  function automatic logic [2:0] model_cmp(input logic [7:0] a, input logic [7:0] b);
`ifdef COMP_BIN_SAR_SIGNED_EN
    return {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
`else
    return {a > b, a == b, a < b};
`endif
  endfunction

  // Comparator with two registered stages.
  always @(posedge clk) begin
    if (force_en) stage1 <= force_flags;
    else          stage1 <= model_cmp(hidden_a, bus.o_B);
    flags_q <= stage1;
  end

  assign bus.i_Mayor = flags_q[2];
  assign bus.i_Igual = flags_q[1];
  assign bus.i_Menor = flags_q[0];

  // Driver: pulse i_Start, record trial values, return cycle of o_Listo (-1 on timeout).
  task automatic run_search(input logic [7:0] a, input int extra_start_cyc,
                            output int cyc, output logic [7:0] res, output logic err);
    logic [7:0] prev_b;
    bit         have_prev;
    hidden_a = a;
    trial_q.delete();
    have_prev = 1'b0;
    prev_b = 8'h00;
    cyc = -1;
    @(negedge clk); bus.i_Start = 1'b1;
    @(negedge clk); bus.i_Start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (dbg_state == 2'd1 && (!have_prev || bus.o_B != prev_b)) begin
        trial_q.push_back(bus.o_B);
        prev_b = bus.o_B;
        have_prev = 1'b1;
      end
      if (bus.o_Listo) begin
        cyc = c;
        break;
      end
      if (c == extra_start_cyc) bus.i_Start = 1'b1;
      @(negedge clk);
      bus.i_Start = 1'b0;
    end
    res = bus.o_Resultado;
    err = bus.o_Error;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Start = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.o_B !== 8'h00) $display("FAIL reset_o_B: got %h expected 00", bus.o_B); else pass_cnt++;
    total_cnt++; if (bus.o_Ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b expected 0", bus.o_Ocupado); else pass_cnt++;
    total_cnt++; if (bus.o_Listo !== 1'b0) $display("FAIL reset_listo: got %b expected 0", bus.o_Listo); else pass_cnt++;
    total_cnt++; if (bus.o_Resultado !== 8'h00) $display("FAIL reset_resultado: got %h expected 00", bus.o_Resultado); else pass_cnt++;
    total_cnt++; if (bus.o_Error !== 1'b0) $display("FAIL reset_error: got %b expected 0", bus.o_Error); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; logic [7:0] res; logic err;
    exp_q = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
    run_search(8'h5A, -1, cyc, res, err);
    total_cnt++; if (cyc !== 22) $display("FAIL basic_latency: got %0d expected 22", cyc); else pass_cnt++;
    total_cnt++; if (res !== 8'h5A) $display("FAIL basic_result: got %h expected 5a", res); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL basic_error: got %b expected 0", err); else pass_cnt++;
    total_cnt++; if (trial_q.size() !== exp_q.size()) $display("FAIL basic_trial_count: got %0d expected %0d", trial_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < trial_q.size(); i++) begin
      total_cnt++; if (trial_q[i] !== exp_q[i]) $display("FAIL basic_trial_%0d: got %h expected %h", i, trial_q[i], exp_q[i]); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (bus.o_Listo !== 1'b0) $display("FAIL basic_listo_pulse: got %b expected 0", bus.o_Listo); else pass_cnt++;
    total_cnt++; if (bus.o_Resultado !== 8'h5A) $display("FAIL basic_result_hold: got %h expected 5a", bus.o_Resultado); else pass_cnt++;
    total_cnt++; if (bus.o_B !== 8'h00) $display("FAIL basic_idle_o_B: got %h expected 00", bus.o_B); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    int cyc; logic [7:0] res; logic err;
    run_search(8'h80, -1, cyc, res, err);
    total_cnt++; if (cyc !== 4) $display("FAIL bnd80_latency: got %0d expected 4", cyc); else pass_cnt++;
    total_cnt++; if (res !== 8'h80) $display("FAIL bnd80_result: got %h expected 80", res); else pass_cnt++;
    run_search(8'hFF, -1, cyc, res, err);
    total_cnt++; if (cyc !== 25) $display("FAIL bndff_latency: got %0d expected 25", cyc); else pass_cnt++;
    total_cnt++; if (res !== 8'hFF) $display("FAIL bndff_result: got %h expected ff", res); else pass_cnt++;
    run_search(8'h00, -1, cyc, res, err);
    total_cnt++; if (cyc !== 25) $display("FAIL bnd00_latency: got %0d expected 25", cyc); else pass_cnt++;
    total_cnt++; if (res !== 8'h00) $display("FAIL bnd00_result: got %h expected 00", res); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL bnd00_error: got %b expected 0", err); else pass_cnt++;
  endtask

  task automatic test_error();
    int cyc; logic [7:0] res; logic err;
    force_en = 1'b1; force_flags = 3'b000;
    run_search(8'h5A, -1, cyc, res, err);
    total_cnt++; if (cyc !== 4) $display("FAIL err000_latency: got %0d expected 4", cyc); else pass_cnt++;
    total_cnt++; if (res !== 8'h00) $display("FAIL err000_result: got %h expected 00", res); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL err000_error: got %b expected 1", err); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.o_Error !== 1'b1) $display("FAIL err_sticky: got %b expected 1", bus.o_Error); else pass_cnt++;
    force_flags = 3'b110;
    run_search(8'h5A, -1, cyc, res, err);
    total_cnt++; if (cyc !== 4) $display("FAIL err110_latency: got %0d expected 4", cyc); else pass_cnt++;
    total_cnt++; if (res !== 8'h80) $display("FAIL err110_result: got %h expected 80", res); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL err110_error: got %b expected 1", err); else pass_cnt++;
    force_en = 1'b0;
    run_search(8'h33, -1, cyc, res, err);
    total_cnt++; if (err !== 1'b0) $display("FAIL err_clear: got %b expected 0", err); else pass_cnt++;
    total_cnt++; if (res !== 8'h33) $display("FAIL err_recover_result: got %h expected 33", res); else pass_cnt++;
    total_cnt++; if (cyc !== 25) $display("FAIL err_recover_latency: got %0d expected 25", cyc); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    hidden_a = 8'h5A;
    @(negedge clk); bus.i_Start = 1'b1;
    @(negedge clk); bus.i_Start = 1'b0;
    repeat (9) @(negedge clk);
    total_cnt++; if (bus.o_Ocupado !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", bus.o_Ocupado); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (bus.o_Ocupado !== 1'b0) $display("FAIL mid_ocupado: got %b expected 0", bus.o_Ocupado); else pass_cnt++;
    total_cnt++; if (bus.o_B !== 8'h00) $display("FAIL mid_o_B: got %h expected 00", bus.o_B); else pass_cnt++;
    total_cnt++; if (bus.o_Resultado !== 8'h00) $display("FAIL mid_resultado: got %h expected 00", bus.o_Resultado); else pass_cnt++;
    total_cnt++; if ({bus.o_Listo, bus.o_Error} !== 2'b00) $display("FAIL mid_listo_error: got %b expected 00", {bus.o_Listo, bus.o_Error}); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL mid_state: got %0d expected 0", dbg_state); else pass_cnt++;
    // Reset and start on the same edge: start is lost.
    rst = 1'b1; bus.i_Start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.i_Start = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.o_Ocupado !== 1'b0) $display("FAIL rst_start_lost: got %b expected 0", bus.o_Ocupado); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int cyc; logic [7:0] res; logic err;
    run_search(8'h5A, 5, cyc, res, err);
    total_cnt++; if (cyc !== 22) $display("FAIL ign_latency: got %0d expected 22", cyc); else pass_cnt++;
    total_cnt++; if (res !== 8'h5A) $display("FAIL ign_result: got %h expected 5a", res); else pass_cnt++;
    // Request held during the o_Listo cycle must not start a new search.
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    total_cnt++; if (bus.o_Ocupado !== 1'b0) $display("FAIL listo_start_dropped: got %b expected 0", bus.o_Ocupado); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL listo_start_state: got %0d expected 0", dbg_state); else pass_cnt++;
  endtask

`ifdef COMP_BIN_SAR_SIGNED_EN
  task automatic test_signed();
    int cyc; logic [7:0] res; logic err;
    exp_q = '{8'h00, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFD};
    run_search(8'hFD, -1, cyc, res, err);
    total_cnt++; if (res !== 8'hFD) $display("FAIL sgn_fd_result: got %h expected fd", res); else pass_cnt++;
    total_cnt++; if (cyc !== 25) $display("FAIL sgn_fd_latency: got %0d expected 25", cyc); else pass_cnt++;
    total_cnt++; if (trial_q.size() !== exp_q.size()) $display("FAIL sgn_trial_count: got %0d expected %0d", trial_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < trial_q.size(); i++) begin
      total_cnt++; if (trial_q[i] !== exp_q[i]) $display("FAIL sgn_trial_%0d: got %h expected %h", i, trial_q[i], exp_q[i]); else pass_cnt++;
    end
    run_search(8'h80, -1, cyc, res, err);
    total_cnt++; if (res !== 8'h80) $display("FAIL sgn_80_result: got %h expected 80", res); else pass_cnt++;
    total_cnt++; if (cyc !== 25) $display("FAIL sgn_80_latency: got %0d expected 25", cyc); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL sgn_80_error: got %b expected 0", err); else pass_cnt++;
  endtask
`endif

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_Start = 1'b0;
    test_reset();
`ifdef COMP_BIN_SAR_SIGNED_EN
    test_signed();
`else
    test_basic();
    test_boundaries();
    test_error();
    test_reset_mid();
    test_start_ignored();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
